div_issue_queue: RTL and testbench

Front-end stage placed directly upstream of the iterative 32-bit signed divider. It buffers divide requests from the pipeline in a small FIFO and launches them one at a time with a single-cycle start pulse. It captures the divider's quotient and exception on its done pulse and returns each result with its destination tag over a valid/ready handshake. It is the only block that drives the divider's start and reset.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_req_fifo.sv | 63 ++++++
 rtl/div_issue_queue.sv | 162 ++++++++++++++++
 tb/tb_div_issue_queue.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider issue queue: data width, FSM states and the queued request record.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } div_issue_state_t;

  typedef struct packed {
    logic [DIV_DATA_W-1:0] dividend;
    logic [DIV_DATA_W-1:0] divisor;
    logic [DIV_TAG_W-1:0]  tag;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider issue queue. The pointers carry one extra wrap bit.
// The count register gives exact full and empty flags.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  div_req_t    i_push_data,
  input  logic        i_pop,
  output div_req_t    o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  div_req_t    r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is cleared on reset so the operand outputs read zero out of reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_queue.sv
// Issue queue in front of the iterative signed divider. It launches queued requests one at a time and returns tagged results.
// With DIV_ZERO_BYPASS_EN defined, zero-divisor requests are answered locally and the divider is not started for them.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DIV_DATA_W-1:0] i_req_dividend,
  input  logic [DIV_DATA_W-1:0] i_req_divisor,
  input  logic [TAG_W-1:0]      i_req_tag,
  output logic                  o_div_start,
  output logic                  o_div_reset,
  output logic [DIV_DATA_W-1:0] o_div_dividend,
  output logic [DIV_DATA_W-1:0] o_div_divisor,
  input  logic [DIV_DATA_W-1:0] i_div_quotient,
  input  logic                  i_div_exception,
  input  logic                  i_div_done,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DIV_DATA_W-1:0] o_res_quotient,
  output logic                  o_res_exception,
  output logic [TAG_W-1:0]      o_res_tag,
  output logic                  o_busy
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | waiting for a queued request
  // ISSUE | start pulse high, head operands on the divider inputs
  // WAIT  | divider running, head operands held until done
  // RESP  | result held on res_* until the consumer accepts it

  div_issue_state_t      r_state;
  logic                  r_div_start;
  logic                  r_div_reset;
  logic                  r_res_valid;
  logic [DIV_DATA_W-1:0] r_res_quotient;
  logic                  r_res_exception;
  logic [TAG_W-1:0]      r_res_tag;

  div_req_t              w_push_data;
  div_req_t              w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [AW:0]           w_count;

  assign w_push_data = '{dividend: i_req_dividend,
                         divisor:  i_req_divisor,
                         tag:      DIV_TAG_W'(i_req_tag)};
  assign w_push      = i_req_valid && !w_full && !i_flush;

`ifdef DIV_ZERO_BYPASS_EN
  logic w_head_zero;
  assign w_head_zero = (w_head.divisor == '0);
`endif

  always_comb begin
    w_pop = 1'b0;
    if (!i_flush) begin
      if (r_state == WAIT && i_div_done) w_pop = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
      if (r_state == IDLE && !w_empty && w_head_zero) w_pop = 1'b1;
`endif
    end
  end

  div_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_div_start     <= 1'b0;
      r_div_reset     <= 1'b0;
      r_res_valid     <= 1'b0;
      r_res_quotient  <= '0;
      r_res_exception <= 1'b0;
      r_res_tag       <= '0;
    end else begin
      r_div_start <= 1'b0;
      r_div_reset <= 1'b0;
      if (i_flush) begin
        // Only a launched divide needs aborting; IDLE and RESP have nothing in the divider.
        r_div_reset <= (r_state == ISSUE) || (r_state == WAIT);
        r_res_valid <= 1'b0;
        r_state     <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_empty) begin
`ifdef DIV_ZERO_BYPASS_EN
              if (w_head_zero) begin
                r_res_quotient  <= '0;
                r_res_exception <= 1'b1;
                r_res_tag       <= TAG_W'(w_head.tag);
                r_res_valid     <= 1'b1;
                r_state         <= RESP;
              end else begin
                r_div_start <= 1'b1;
                r_state     <= ISSUE;
              end
`else
              r_div_start <= 1'b1;
              r_state     <= ISSUE;
`endif
            end
          end
          ISSUE: r_state <= WAIT;
          WAIT: begin
            if (i_div_done) begin
              r_res_quotient  <= i_div_quotient;
              r_res_exception <= i_div_exception;
              r_res_tag       <= TAG_W'(w_head.tag);
              r_res_valid     <= 1'b1;
              r_state         <= RESP;
            end
          end
          RESP: begin
            if (i_res_ready) begin
              r_res_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_req_ready     = !w_full;
  assign o_div_start     = r_div_start;
  assign o_div_reset     = r_div_reset;
  assign o_div_dividend  = w_head.dividend;
  assign o_div_divisor   = w_head.divisor;
  assign o_res_valid     = r_res_valid;
  assign o_res_quotient  = r_res_quotient;
  assign o_res_exception = r_res_exception;
  assign o_res_tag       = r_res_tag;
  assign o_busy          = (w_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: a divider stand-in (33 cycles normal, 3 cycles for zero divisor) and a result model built on plain signed division.
module tb_div_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_dividend, req_divisor;
  logic [4:0]  req_tag;
  logic        div_start, div_reset;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient;
  logic        div_exception, div_done;
  logic        res_valid, res_ready;
  logic [31:0] res_quotient;
  logic        res_exception;
  logic [4:0]  res_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] q;
    logic        e;
    logic [4:0]  tag;
  } exp_t;

  always #5 clk = ~clk;

  div_issue_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_flush         (flush),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .i_req_tag       (req_tag),
    .o_div_start     (div_start),
    .o_div_reset     (div_reset),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .i_div_quotient  (div_quotient),
    .i_div_exception (div_exception),
    .i_div_done      (div_done),
    .o_res_valid     (res_valid),
    .i_res_ready     (res_ready),
    .o_res_quotient  (res_quotient),
    .o_res_exception (res_exception),
    .o_res_tag       (res_tag),
    .o_busy          (busy)
  );

  // Divider stand-in: done arrives L cycles after the start pulse is seen.
  logic        m_done, m_exc, m_busy, t_done;
  logic [31:0] m_q, m_a, m_b;
  int          m_cnt;
  int          start_cnt = 0;
  int          reset_cnt = 0;
  time         start_t[$];

  assign div_done      = m_done | t_done;
  assign div_quotient  = m_q;
  assign div_exception = m_exc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_q    <= '0;
      m_exc  <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_reset) m_busy <= 1'b0;
      else if (div_start) begin
        m_busy <= 1'b1;
        m_a    <= div_dividend;
        m_b    <= div_divisor;
        m_cnt  <= (div_divisor == 0) ? 2 : 32;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          if (m_b == 0) begin
            m_q   <= 32'hFFFF_FFFF;
            m_exc <= 1'b1;
          end else begin
            m_q   <= $signed(m_a) / $signed(m_b);
            m_exc <= 1'b0;
          end
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (div_start) begin
        start_cnt++;
        start_t.push_back($time);
      end
      if (div_reset) reset_cnt++;
    end
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    exp_t r;
    r.tag = t;
    if (b == 0) begin
      r.e = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
      r.q = '0;
`else
      r.q = 32'hFFFF_FFFF;
`endif
    end else begin
      r.e = 1'b0;
      r.q = $signed(a) / $signed(b);
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t, output bit ok);
    ok           = 1'b0;
    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    req_tag      = t;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc, output bit ok);
    cyc = 0;
    while (!res_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    ok = res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, div_start, div_reset, res_valid, res_exception, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000", {req_ready, div_start, div_reset, res_valid, res_exception, busy});
    end
    checks++;
    if ({div_dividend, div_divisor, res_quotient, res_tag} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%h expected all zero", div_dividend, div_divisor, res_quotient, res_tag);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok, ok2;
    int cyc, s0;
    res_ready = 1'b1;
    s0 = start_cnt;
    send(32'd100, 32'd7, 5'd3, ok);
    wait_res(cyc, ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL basic_handshake: accepted=%0b result=%0b expected 1/1", ok, ok2);
    end
    checks++;
    if ({res_quotient, res_exception, res_tag} !== {32'd14, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL basic_100_7: got %h/%b/%0d expected 0000000e/0/3", res_quotient, res_exception, res_tag);
    end
    // Sampled one cycle after acceptance, so 3 + 33 total latency shows as 35.
    checks++;
    if (cyc !== 35) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 35", cyc);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL basic_single_start: valid=%b starts=%0d expected 0/1", res_valid, start_cnt - s0);
    end
    send(-32'sd100, 32'd7, 5'd4, ok);
    wait_res(cyc, ok2);
    checks++;
    if ({res_quotient, res_exception, res_tag} !== {32'hFFFF_FFF2, 1'b0, 5'd4}) begin
      errors++;
      $display("FAIL neg_dividend: got %h/%b/%0d expected fffffff2/0/4", res_quotient, res_exception, res_tag);
    end
    @(negedge clk);
    send(32'd7, -32'sd2, 5'd5, ok);
    wait_res(cyc, ok2);
    checks++;
    if ({res_quotient, res_exception, res_tag} !== {32'hFFFF_FFFD, 1'b0, 5'd5}) begin
      errors++;
      $display("FAIL neg_divisor: got %h/%b/%0d expected fffffffd/0/5", res_quotient, res_exception, res_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int cyc, s0;
    exp_t ex[3];
    logic [31:0] a, b;
    res_ready = 1'b1;
    s0 = start_t.size();
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 5000));
      ex[i] = model(a, b, 5'(10 + i));
      send(a, b, 5'(10 + i), ok);
    end
    for (int i = 0; i < 3; i++) begin
      wait_res(cyc, ok2);
      checks++;
      if (!ok2 || {res_quotient, res_exception, res_tag} !== ex[i]) begin
        errors++;
        $display("FAIL b2b_result%0d: got %h/%b/%0d expected %h/%b/%0d", i, res_quotient, res_exception, res_tag, ex[i].q, ex[i].e, ex[i].tag);
      end
      @(negedge clk);
    end
    checks++;
    if (start_t.size() - s0 !== 3 || (start_t[s0+1] - start_t[s0]) !== 360 || (start_t[s0+2] - start_t[s0+1]) !== 360) begin
      errors++;
      $display("FAIL b2b_throughput: starts=%0d expected 3 with 36-cycle spacing", start_t.size() - s0);
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int cyc, s0;
    exp_t ex[5];
    logic [31:0] a, b;
    res_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 1000));
      ex[i] = model(a, b, 5'(i));
      send(a, b, 5'(i), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_accept%0d: accepted=0 expected 1", i);
      end
      if (i == 3) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full: req_ready=%b expected 0", req_ready);
        end
      end
    end
    checks++;
    if (res_valid !== 1'b1 || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL bp_fifth_after_pop: valid=%b starts=%0d expected 1/1", res_valid, start_cnt - s0);
    end
    for (int i = 0; i < 5; i++) begin
      wait_res(cyc, ok2);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok2 || res_valid !== 1'b1 || {res_quotient, res_exception, res_tag} !== ex[i]) begin
        errors++;
        $display("FAIL bp_result%0d: valid=%b got %h/%b/%0d expected %h/%b/%0d", i, res_valid, res_quotient, res_exception, res_tag, ex[i].q, ex[i].e, ex[i].tag);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_div_zero();
    bit ok, ok2;
    int cyc, s0, exp_cyc, exp_starts;
    exp_t ex;
    res_ready = 1'b1;
    s0 = start_cnt;
    ex = model(32'd50, 32'd0, 5'd7);
`ifdef DIV_ZERO_BYPASS_EN
    exp_cyc = 1;
    exp_starts = 0;
`else
    exp_cyc = 5;
    exp_starts = 1;
`endif
    send(32'd50, 32'd0, 5'd7, ok);
    wait_res(cyc, ok2);
    checks++;
    if (!ok2 || {res_quotient, res_exception, res_tag} !== ex) begin
      errors++;
      $display("FAIL zero_result: got %h/%b/%0d expected %h/%b/%0d", res_quotient, res_exception, res_tag, ex.q, ex.e, ex.tag);
    end
    checks++;
    if (cyc !== exp_cyc || start_cnt - s0 !== exp_starts) begin
      errors++;
      $display("FAIL zero_timing: cycles=%0d starts=%0d expected %0d/%0d", cyc, start_cnt - s0, exp_cyc, exp_starts);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit ok, seen_valid;
    int s0, r0, n;
    res_ready = 1'b1;
    s0 = start_cnt;
    r0 = reset_cnt;
    send(32'd1000, 32'd3, 5'd20, ok);
    send(32'd2000, 32'd9, 5'd21, ok);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    flush        = 1'b1;
    req_valid    = 1'b1;
    req_dividend = 32'd77;
    req_divisor  = 32'd11;
    req_tag      = 5'd22;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if ({div_reset, busy, res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL flush_next_cycle: reset/busy/valid=%b expected 100", {div_reset, busy, res_valid});
    end
    @(negedge clk);
    checks++;
    if (div_reset !== 1'b0 || reset_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL flush_reset_pulse: div_reset=%b pulses=%0d expected 0/1", div_reset, reset_cnt - r0);
    end
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_valid || busy !== 1'b0 || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL flush_quiet: valid_seen=%b busy=%b starts=%0d expected 0/0/1", seen_valid, busy, start_cnt - s0);
    end
  endtask

  exp_t rq[$];
  int   r_got;

  task automatic test_random();
    localparam int N = 24;
    r_got = 0;
    rq.delete();
    fork
      begin : producer
        logic [31:0] a, b;
        bit ok;
        for (int i = 0; i < N; i++) begin
          a = $urandom;
          b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
          send(a, b, 5'(i), ok);
          if (!ok) begin
            errors++;
            $display("FAIL rand_accept%0d: accepted=0 expected 1", i);
            break;
          end
          rq.push_back(model(a, b, 5'(i)));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin : consumer
        exp_t e;
        for (int c = 0; c < 6000 && r_got < N; c++) begin
          res_ready = 1'($urandom_range(0, 1));
          if (res_valid && res_ready) begin
            e = (rq.size() > 0) ? rq.pop_front() : '0;
            checks++;
            if ({res_quotient, res_exception, res_tag} !== e) begin
              errors++;
              $display("FAIL rand_result%0d: got %h/%b/%0d expected %h/%b/%0d", r_got, res_quotient, res_exception, res_tag, e.q, e.e, e.tag);
            end
            r_got++;
          end
          @(negedge clk);
        end
      end
    join
    checks++;
    if (r_got !== N) begin
      errors++;
      $display("FAIL rand_count: got %0d results expected %0d", r_got, N);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    bit ok, ok2;
    int cyc, s0;
    res_ready = 1'b0;
    send(32'd84, 32'd4, 5'd9, ok);
    send(32'd5, 32'd1, 5'd1, ok);
    wait_res(cyc, ok2);
    checks++;
    if (!ok2) begin
      errors++;
      $display("FAIL resp_reached: valid=%b expected 1", res_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, div_start, busy, req_ready} !== 4'b0001 || {res_quotient, res_tag} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid/start/busy/ready=%b q=%h tag=%0d expected 0001/0/0", {res_valid, div_start, busy, req_ready}, res_quotient, res_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if ({req_ready, busy, res_valid} !== 3'b100 || start_cnt !== s0) begin
      errors++;
      $display("FAIL after_reset: ready/busy/valid=%b starts=%0d expected 100/0", {req_ready, busy, res_valid}, start_cnt - s0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    req_valid    = 1'b0;
    req_dividend = '0;
    req_divisor  = '0;
    req_tag      = '0;
    res_ready    = 1'b0;
    t_done       = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_div_zero();
    test_flush();
    test_random();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
